mem_access_unit: RTL

- Memory-stage block directly downstream of the execute ALU in the RISC-V core.
- Consumes the ALU result as an effective address for loads/stores, or passes it through for non-memory ops.
- Drives a variable-latency data-memory req/ack handshake; formats load data (byte/half/word, signed/unsigned); raises alignment, width and timeout exceptions.
- Returns one writeback record per accepted op.

---
 rtl/mau_pkg.sv | 42 ++++
 rtl/load_formatter.sv | 29 ++
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Shared constants, types and decode helpers for the memory access unit.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  // Unsigned widths only exist for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    case (f3)
      F3_H, F3_HU: m = lo[0];
      F3_W:        m = (lo != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/half/word from a read word and sign- or zero-extends it.
module load_formatter
  import mau_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Width/sign selection of the extracted lane.
  always_comb begin
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_W:    data = rdata;
      F3_BU:   data = {24'h000000, lane_b};
      F3_HU:   data = {16'h0000, lane_h};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: accepts an execute-stage op, runs a req/ack data-memory access with
// timeout, and returns one registered writeback record per accepted op.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_wdata,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_exc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lo_q, lo_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       strb_q, strb_d;
  logic             wbv_q, wbv_d;
  logic [4:0]       wbrd_q, wbrd_d;
  logic [31:0]      wbdata_q, wbdata_d;
  logic [1:0]       wbexc_q, wbexc_d;

  logic [31:0] ld_data;
  logic        is_mem, illegal, misalign;

  load_formatter u_fmt (
    .rdata  (dm_rdata),
    .addr_lo(lo_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  assign is_mem   = ex_mem_read | ex_mem_write;
  assign illegal  = (ex_mem_read & ex_mem_write) | (is_mem & ~f3_legal(ex_funct3, ex_mem_write));
  assign misalign = misaligned(ex_funct3, ex_result[1:0]);

  // Next-state, access request and writeback record computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    wbv_d    = 1'b0;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    wbexc_d  = wbexc_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          rd_d     = ex_rd;
          wbrd_d   = ex_rd;
          wbdata_d = 32'h0000_0000;
          wbexc_d  = EXC_NONE;
          if (!is_mem) begin
            state_d  = RESP;
            wbv_d    = 1'b1;
            wbdata_d = ex_result;
          end else if (illegal) begin
            state_d = RESP;
            wbv_d   = 1'b1;
            wbexc_d = EXC_ILLEGAL;
          end else if (misalign) begin
            state_d = RESP;
            wbv_d   = 1'b1;
            wbexc_d = EXC_MISALIGN;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            addr_d  = {ex_result[31:2], 2'b00};
            f3_d    = ex_funct3;
            lo_d    = ex_result[1:0];
            if (ex_mem_write) begin
              case (ex_funct3)
                F3_B: begin
                  wdata_d = {4{ex_wdata[7:0]}};
                  strb_d  = 4'b0001 << ex_result[1:0];
                end
                F3_H: begin
                  wdata_d = {2{ex_wdata[15:0]}};
                  strb_d  = 4'b0011 << ex_result[1:0];
                end
                default: begin
                  wdata_d = ex_wdata;
                  strb_d  = 4'b1111;
                end
              endcase
            end else begin
              wdata_d = 32'h0000_0000;
              strb_d  = 4'b0000;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle takes priority over the timeout.
        if (dm_ack) begin
          state_d  = RESP;
          req_d    = 1'b0;
          wbv_d    = 1'b1;
          wbrd_d   = rd_q;
          wbexc_d  = EXC_NONE;
          wbdata_d = we_q ? 32'h0000_0000 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          req_d    = 1'b0;
          wbv_d    = 1'b1;
          wbrd_d   = rd_q;
          wbexc_d  = EXC_TIMEOUT;
          wbdata_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d  = IDLE;
        wbrd_d   = 5'd0;
        wbdata_d = 32'h0000_0000;
        wbexc_d  = EXC_NONE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
      rd_q     <= 5'd0;
      f3_q     <= 3'd0;
      lo_q     <= 2'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      strb_q   <= 4'b0000;
      wbv_q    <= 1'b0;
      wbrd_q   <= 5'd0;
      wbdata_q <= 32'h0000_0000;
      wbexc_q  <= EXC_NONE;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      wbv_q    <= wbv_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      wbexc_q  <= wbexc_d;
    end
  end

  assign ex_ready = ready_q;
  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign dm_wstrb = strb_q;
  assign wb_valid = wbv_q;
  assign wb_rd    = wbrd_q;
  assign wb_data  = wbdata_q;
  assign wb_exc   = wbexc_q;

endmodule
